// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller for the 8-bit ALU: owns the register file and Z/C flags.
// Optional perf counters are enabled by defining ALU_ISSUE_PERF_CNT_EN.
module alu_issue_ctrl #(
  parameter int         RF_AW        = 2,
  parameter logic [7:0] RF_RESET_VAL = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [RF_AW-1:0] instr_rd,
  input  logic [RF_AW-1:0] instr_rs,
  input  logic             instr_imm_sel,
  input  logic [7:0]       instr_imm,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [7:0]       alu_result,
  input  logic             alu_flag_z,
  input  logic             alu_flag_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_z,
  output logic             rsp_c,
  output logic             rsp_err
`ifdef ALU_ISSUE_PERF_CNT_EN
  ,
  output logic [15:0]      perf_retired,
  output logic [15:0]      perf_illegal
`endif
);

  localparam int RF_DEPTH = 1 << RF_AW;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [7:0]       rf [RF_DEPTH];
  logic             flag_z;
  logic             flag_c;
  logic [2:0]       op_p0;
  logic [RF_AW-1:0] rd_p0;

  // CMP reuses the ALU subtractor; LDI and illegal opcodes park the ALU on ADD.
  function automatic logic [2:0] map_alu_op(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_EOR: map_alu_op = op;
      OP_CMP:                                map_alu_op = OP_SUB;
      default:                               map_alu_op = OP_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= RF_RESET_VAL;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      op_p0       <= OP_ADD;
      rd_p0       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= OP_ADD;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_z       <= 1'b0;
      rsp_c       <= 1'b0;
      rsp_err     <= 1'b0;
`ifdef ALU_ISSUE_PERF_CNT_EN
      perf_retired <= '0;
      perf_illegal <= '0;
`endif
    end else begin
      case (state)
        // Accept: operands are read from the register file at this edge.
        IDLE: begin
          if (instr_valid) begin
            op_p0       <= instr_op;
            rd_p0       <= instr_rd;
            alu_a       <= rf[instr_rd];
            alu_b       <= instr_imm_sel ? instr_imm : rf[instr_rs];
            alu_opcode  <= map_alu_op(instr_op);
            instr_ready <= 1'b0;
            state       <= EXEC;
          end
        end
        // Execute: capture ALU outputs, write back, and stage the response.
        EXEC: begin
          case (op_p0)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_EOR: begin
              rf[rd_p0]  <= alu_result;
              flag_z     <= alu_flag_z;
              flag_c     <= alu_flag_c;
              rsp_result <= alu_result;
              rsp_z      <= alu_flag_z;
              rsp_c      <= alu_flag_c;
              rsp_err    <= 1'b0;
            end
            OP_CMP: begin
              flag_z     <= alu_flag_z;
              flag_c     <= alu_flag_c;
              rsp_result <= alu_result;
              rsp_z      <= alu_flag_z;
              rsp_c      <= alu_flag_c;
              rsp_err    <= 1'b0;
            end
            OP_LDI: begin
              rf[rd_p0]  <= alu_b;
              flag_z     <= (alu_b == 8'h00);
              rsp_result <= alu_b;
              rsp_z      <= (alu_b == 8'h00);
              rsp_c      <= flag_c;
              rsp_err    <= 1'b0;
            end
            default: begin
              rsp_result <= '0;
              rsp_z      <= flag_z;
              rsp_c      <= flag_c;
              rsp_err    <= 1'b1;
            end
          endcase
          alu_a      <= '0;
          alu_b      <= '0;
          alu_opcode <= OP_ADD;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        // Respond: hold rsp_* until the consumer takes them.
        RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            instr_ready <= 1'b1;
            state       <= IDLE;
`ifdef ALU_ISSUE_PERF_CNT_EN
            if (rsp_err) perf_illegal <= perf_illegal + 16'd1;
            else         perf_retired <= perf_retired + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a response scoreboard.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = '0;
  logic [1:0] instr_rd = '0;
  logic [1:0] instr_rs = '0;
  logic       instr_imm_sel = 1'b0;
  logic [7:0] instr_imm = '0;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_opcode;
  logic [7:0] alu_result;
  logic       alu_flag_z, alu_flag_c;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_z, rsp_c, rsp_err;
`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [15:0] perf_retired, perf_illegal;
  int          m_ret = 0, m_ill = 0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       c;
    logic       err;
  } exp_t;
  exp_t sb[$];

  logic [7:0] m_rf [4];
  logic       m_z, m_c;

  alu_issue_ctrl #(.RF_AW(2), .RF_RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
    .instr_imm_sel(instr_imm_sel), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_flag_z(alu_flag_z), .alu_flag_c(alu_flag_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_err(rsp_err)
`ifdef ALU_ISSUE_PERF_CNT_EN
    , .perf_retired(perf_retired), .perf_illegal(perf_illegal)
`endif
  );

  always #5 clk = ~clk;

  // Combinational 8-bit ALU the controller drives.
  always_comb begin
    alu_result = '0;
    alu_flag_c = 1'b0;
    case (alu_opcode)
      3'b000: {alu_flag_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: begin
        alu_result = alu_a - alu_b;
        alu_flag_c = (alu_a >= alu_b);
      end
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      default: ;
    endcase
    alu_flag_z = (alu_result == 8'h00);
  end

  always @(negedge clk) begin
    checks++;
    assert (alu_opcode <= 3'b100) else begin
      errors++;
      $error("FAIL alu_opcode_range: observed %0h expected <= 4", alu_opcode);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_alu_op(input logic [2:0] op);
    if (op <= 3'b100) return op;
    if (op == 3'b110) return 3'b001;
    return 3'b000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_z = 1'b0;
    m_c = 1'b0;
    sb.delete();
`ifdef ALU_ISSUE_PERF_CNT_EN
    m_ret = 0;
    m_ill = 0;
`endif
  endtask

  task automatic do_instr(input string tag, input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] rs, input logic sel, input logic [7:0] imm,
                          input int hold);
    logic [7:0] a, b, r;
    logic [8:0] s;
    exp_t e;
    @(negedge clk);
    chk({tag, ".ready"}, instr_ready, 1);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs;
    instr_imm_sel = sel; instr_imm = imm;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_op = 3'($urandom); instr_rd = 2'($urandom); instr_rs = 2'($urandom);
    instr_imm_sel = 1'($urandom); instr_imm = 8'($urandom);
    a = m_rf[rd];
    b = sel ? imm : m_rf[rs];
    chk({tag, ".exec_ready"}, instr_ready, 0);
    chk({tag, ".exec_valid"}, rsp_valid, 0);
    chk({tag, ".alu_op"}, alu_opcode, exp_alu_op(op));
    chk({tag, ".alu_a"}, alu_a, a);
    chk({tag, ".alu_b"}, alu_b, b);
    e.err = 1'b0;
    case (op)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; m_c = s[8]; end
      3'b001, 3'b110: begin r = a - b; m_c = (a >= b); end
      3'b010: begin r = a & b; m_c = 1'b0; end
      3'b011: begin r = a | b; m_c = 1'b0; end
      3'b100: begin r = a ^ b; m_c = 1'b0; end
      3'b101: r = b;
      default: begin r = 8'h00; e.err = 1'b1; end
    endcase
    if (!e.err) m_z = (r == 8'h00);
    if (op != 3'b110 && !e.err) m_rf[rd] = r;
    e.r = r; e.z = m_z; e.c = m_c;
    sb.push_back(e);
    @(posedge clk); #1;
    chk({tag, ".latency"}, rsp_valid, 1);
    chk({tag, ".alu_idle"}, {alu_a, alu_b, 5'(alu_opcode)}, 0);
    e = sb.pop_front();
    chk({tag, ".result"}, rsp_result, e.r);
    chk({tag, ".zce"}, {rsp_z, rsp_c, rsp_err}, {e.z, e.c, e.err});
    for (int i = 0; i < hold; i++) begin
      // Offer an intruding instruction that must not be taken while in RESP.
      instr_valid = 1'b1; instr_op = 3'b101; instr_rd = 2'd2; instr_imm_sel = 1'b1;
      instr_imm = 8'hEE;
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, rsp_valid, 1);
      chk({tag, ".hold_ready"}, instr_ready, 0);
      chk({tag, ".hold_rsp"}, {rsp_result, rsp_z, rsp_c, rsp_err}, {e.r, e.z, e.c, e.err});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    instr_valid = 1'b0;
    chk({tag, ".done_valid"}, rsp_valid, 0);
    chk({tag, ".done_ready"}, instr_ready, 1);
`ifdef ALU_ISSUE_PERF_CNT_EN
    if (e.err) m_ill++;
    else       m_ret++;
    chk({tag, ".perf_ret"}, perf_retired, m_ret);
    chk({tag, ".perf_ill"}, perf_illegal, m_ill);
`endif
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst.ready", instr_ready, 1);
    chk("rst.rsp", {rsp_valid, rsp_result, rsp_z, rsp_c, rsp_err}, 0);
    chk("rst.alu", {alu_a, alu_b, 5'(alu_opcode)}, 0);
    @(negedge clk);
    rst = 1'b0;

    do_instr("ldi_r1", 3'b101, 2'd1, 2'd0, 1'b1, 8'h05, 0);
    do_instr("ldi_r2", 3'b101, 2'd2, 2'd0, 1'b1, 8'h03, 0);
    do_instr("add_r1r2", 3'b000, 2'd1, 2'd2, 1'b0, 8'h00, 0);
    do_instr("rd_r1", 3'b000, 2'd1, 2'd0, 1'b1, 8'h00, 0);
    do_instr("ldi_r0", 3'b101, 2'd0, 2'd0, 1'b1, 8'hFF, 0);
    do_instr("add_wrap", 3'b000, 2'd0, 2'd0, 1'b1, 8'h01, 0);
    do_instr("ldi_r3", 3'b101, 2'd3, 2'd0, 1'b1, 8'h10, 0);
    do_instr("cmp_eq", 3'b110, 2'd3, 2'd0, 1'b1, 8'h10, 0);
    do_instr("rd_r3", 3'b000, 2'd3, 2'd0, 1'b1, 8'h00, 0);
    do_instr("sub_borrow", 3'b001, 2'd3, 2'd0, 1'b1, 8'h11, 0);
    do_instr("and_r1r2", 3'b010, 2'd1, 2'd2, 1'b0, 8'h00, 0);
    do_instr("or_r2r3", 3'b011, 2'd2, 2'd3, 1'b0, 8'h00, 0);
    do_instr("eor_imm", 3'b100, 2'd2, 2'd0, 1'b1, 8'h5A, 0);
    do_instr("add_rdrs", 3'b000, 2'd3, 2'd3, 1'b0, 8'h00, 0);
    do_instr("illegal", 3'b111, 2'd3, 2'd1, 1'b1, 8'h44, 0);
    do_instr("rd_r3b", 3'b000, 2'd3, 2'd0, 1'b1, 8'h00, 0);
    do_instr("hold5", 3'b001, 2'd1, 2'd3, 1'b0, 8'h00, 5);
    do_instr("rd_r2", 3'b000, 2'd2, 2'd0, 1'b1, 8'h00, 0);

    // Reset asserted while ADD r1,r2 is in EXEC.
    do_instr("ldi_r1b", 3'b101, 2'd1, 2'd0, 1'b1, 8'h21, 0);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 3'b000; instr_rd = 2'd1; instr_rs = 2'd2;
    instr_imm_sel = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("rstx.in_exec", instr_ready, 0);
    rst = 1'b1;
    #1;
    chk("rstx.valid", rsp_valid, 0);
    chk("rstx.ready", instr_ready, 1);
    chk("rstx.alu", {alu_a, alu_b, 5'(alu_opcode)}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rstx.no_rsp", rsp_valid, 0);
      chk("rstx.ready_after", instr_ready, 1);
    end
    do_instr("rstx.r1", 3'b000, 2'd1, 2'd0, 1'b1, 8'h00, 0);
    do_instr("rstx.add", 3'b000, 2'd2, 2'd1, 1'b0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing front-end that drives the 8-bit ALU: accepts one instruction per valid/ready handshake and reads operands from a 4-entry 8-bit register file.
- Presents operands and opcode to the combinational ALU, captures result and flags, writes back, then returns a response over a second valid/ready handshake.
- Sits between instruction fetch/decode and the ALU; owns the architectural register file and the Z/C flag register.

Parameters:
RF_AW, 2, register-file address width (depth = 2**RF_AW); operand/result width fixed at 8 to match the ALU
RF_RESET_VAL, 8'h00, reset value of every register-file entry

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
instr_valid  input  1  instruction offered
instr_ready  output  1  controller can accept (high only in IDLE)
instr_op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 EOR, 101 LDI, 110 CMP, 111 illegal
instr_rd  input  RF_AW  destination and first-operand register
instr_rs  input  RF_AW  second-operand register
instr_imm_sel  input  1  1: second operand = instr_imm
instr_imm  input  8  immediate
alu_a  output  8  ALU operand a
alu_b  output  8  ALU operand b
alu_opcode  output  3  ALU opcode, always in 000..100
alu_result  input  8  ALU result
alu_flag_z  input  1  ALU zero flag
alu_flag_c  input  1  ALU carry flag
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed
rsp_result  output  8  result of the instruction
rsp_z  output  1  Z flag after the instruction
rsp_c  output  1  C flag after the instruction
rsp_err  output  1  illegal opcode

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - All RF entries = RF_RESET_VAL.
  - flag_z = 0, flag_c = 0.
  - rsp_valid = 0, rsp_result = 0, rsp_z = 0, rsp_c = 0, rsp_err = 0.
  - alu_a = alu_b = 0, alu_opcode = 000.
  - Reset mid-instruction discards it; no writeback and no response.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch op, rd, a = RF[rd], b = imm_sel ? imm : RF[rs]; go EXEC.
  - Operands are read from RF at the accept edge.
- EXEC (one cycle):
  - alu_a/alu_b/alu_opcode are driven from the latched registers.
  - Opcode mapping: CMP -> 001; LDI and illegal -> 000.
  - At the end of EXEC the controller captures the result, updates RF/flags and goes RESP, per opcode:
    - ADD/SUB/AND/OR/EOR: RF[rd] = alu_result; flags = ALU flags (C is 0 for logic ops, per ALU).
    - CMP: flags = ALU flags; no RF write; rsp_result = alu_result.
    - LDI: RF[rd] = b; Z = (b == 0); C unchanged; ALU output ignored.
    - Illegal (111): no RF or flag change; rsp_err = 1; rsp_result = 0; rsp_z/rsp_c = current flags.
- RESP:
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - On rsp_ready, rsp_valid drops next cycle and the state returns to IDLE.
  - rsp_ready is ignored when rsp_valid = 0.
- Latency and throughput:
  - Accept edge at cycle N -> rsp_valid high in cycle N+2.
  - Max throughput is one instruction per 3 cycles with rsp_ready tied high.
- Outside EXEC: alu_a = alu_b = 0, alu_opcode = 000. The controller never drives ALU opcodes 101-111.
- rd == rs is legal: both operands equal the same old value; writeback happens after the read.
- Arithmetic wraps modulo 256; SUB carry = no-borrow (ALU semantics).
- instr_* are don't-care outside the accept cycle.

Optional Feature:
- Macro ALU_ISSUE_PERF_CNT_EN.
- When defined, the block adds these outputs:
  - perf_retired [15:0]: counts completed legal instructions.
  - perf_illegal [15:0]: counts illegal opcodes.
- Counters increment on the RESP handshake, wrap at 16'hFFFF -> 0, and reset to 0.
- When not defined, neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- LDI r1,#8'h05; LDI r2,#8'h03; ADD r1,r2 -> rsp_result 8'h08, Z=0, C=0; r1 = 8'h08; rsp_valid exactly 2 cycles after accept.
- LDI r0,#8'hFF; ADD r0,#8'h01 (imm) -> rsp_result 8'h00, Z=1, C=1.
- LDI r3,#8'h10; CMP r3,#8'h10 -> result 8'h00, Z=1, C=1, r3 still 8'h10; then SUB r3,#8'h11 -> 8'hFF, Z=0, C=0.
- Issue op 111 -> rsp_err=1, rsp_result 8'h00, flags and RF unchanged; with ALU_ISSUE_PERF_CNT_EN, perf_illegal = 1 and perf_retired unchanged.
- Hold rsp_ready low 5 cycles during RESP -> rsp_* stable, instr_ready stays 0; a new instr_valid is not accepted until the cycle after the handshake.
- Assert rst during EXEC of ADD r1,r2 -> r1 = 8'h00, rsp_valid never rises, instr_ready = 1 after release; the ALU opcode is never outside 000..100 at any cycle (assertion).
